// File: rtl/wb_arb_pkg.sv
// Shared definitions for the 8-way writeback round-robin arbiter.
package wb_arb_pkg;
   localparam int NREQ  = 8;
   localparam int SELW  = 3;
   localparam int WIDTH = 64;

   typedef logic [SELW-1:0] src_t;

   // First requester at or after ptr, wrapping 7 -> 0; returns ptr when nothing requests.
   function automatic src_t rr_pick(input logic [NREQ-1:0] req, input src_t ptr);
      src_t idx;
      rr_pick = ptr;
      for (int k = NREQ-1; k >= 0; k--) begin
         idx = ptr + src_t'(k);
         if (req[idx]) rr_pick = idx;
      end
   endfunction
endpackage

// File: rtl/mux8_1x64.sv
// Plain 8:1 multiplexer, 64 bits wide.
module mux8_1x64 (
   input  logic [63:0] in0,
   input  logic [63:0] in1,
   input  logic [63:0] in2,
   input  logic [63:0] in3,
   input  logic [63:0] in4,
   input  logic [63:0] in5,
   input  logic [63:0] in6,
   input  logic [63:0] in7,
   input  logic [2:0]  sel,
   output logic [63:0] out
);
   always_comb begin
      case (sel)
         3'd0:    out = in0;
         3'd1:    out = in1;
         3'd2:    out = in2;
         3'd3:    out = in3;
         3'd4:    out = in4;
         3'd5:    out = in5;
         3'd6:    out = in6;
         default: out = in7;
      endcase
   end
endmodule

// File: rtl/wb_rr_arbiter8.sv
// Round-robin arbiter sharing one 64-bit writeback bus among 8 sources,
// with locked bursts and a single-entry valid/ready output register.
module wb_rr_arbiter8 #(
   parameter int WIDTH = 64,
   parameter int NREQ  = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ-1:0]       lock,
   input  logic [NREQ*WIDTH-1:0] din,
   output logic [NREQ-1:0]       ack,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      out_data,
   output logic [2:0]            out_src
);
   import wb_arb_pkg::src_t;
   import wb_arb_pkg::rr_pick;

   src_t             ptr_q, ptr_d, lock_owner_q, lock_owner_d, out_src_q, out_src_d, winner;
   logic             lock_active_q, lock_active_d, out_valid_q, out_valid_d;
   logic             cap_en, locked_hit;
   logic [WIDTH-1:0] out_data_q, out_data_d, mux_out;

   mux8_1x64 u_mux (
      .in0 (din[0*WIDTH +: WIDTH]),
      .in1 (din[1*WIDTH +: WIDTH]),
      .in2 (din[2*WIDTH +: WIDTH]),
      .in3 (din[3*WIDTH +: WIDTH]),
      .in4 (din[4*WIDTH +: WIDTH]),
      .in5 (din[5*WIDTH +: WIDTH]),
      .in6 (din[6*WIDTH +: WIDTH]),
      .in7 (din[7*WIDTH +: WIDTH]),
      .sel (winner),
      .out (mux_out)
   );

   always_comb begin
      locked_hit    = lock_active_q && req[lock_owner_q];
      winner        = locked_hit ? lock_owner_q : rr_pick(req, ptr_q);
      cap_en        = (!out_valid_q || out_ready) && (|req);
      ack           = '0;
      ptr_d         = ptr_q;
      lock_active_d = lock_active_q;
      lock_owner_d  = lock_owner_q;
      out_valid_d   = out_valid_q;
      out_data_d    = out_data_q;
      out_src_d     = out_src_q;
      if (cap_en) begin
         if (!reset) ack[winner] = 1'b1;
         out_valid_d   = 1'b1;
         out_data_d    = mux_out;
         out_src_d     = winner;
         lock_active_d = lock[winner];
         lock_owner_d  = winner;
         // Grants made through a held lock leave the pointer where the burst started.
         if (!locked_hit) ptr_d = winner + src_t'(1);
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q         <= '0;
         lock_active_q <= 1'b0;
         lock_owner_q  <= '0;
         out_valid_q   <= 1'b0;
         out_data_q    <= '0;
         out_src_q     <= '0;
      end else begin
         ptr_q         <= ptr_d;
         lock_active_q <= lock_active_d;
         lock_owner_q  <= lock_owner_d;
         out_valid_q   <= out_valid_d;
         out_data_q    <= out_data_d;
         out_src_q     <= out_src_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_src   = out_src_q;
endmodule

// File: doc/wb_rr_arbiter8.md
Name: wb_rr_arbiter8

Overview:
- Round-robin arbiter that shares one 64-bit result bus among 8 requesters, e.g. the ALU, the memory load path, the multiplier and the forwarding taps.
- Picks one requesting source per cycle and drives the select of an internal 64-bit 8:1 mux.
- Registers the chosen word into a single-entry output stage with a valid/ready handshake toward writeback.
- Supports locked bursts, so one requester keeps the bus for back-to-back words.

Parameters:
- WIDTH, 64, data width per requester. Fixed at 64 to match the 8:1 x64 mux; other values are illegal.
- NREQ, 8, number of requesters. Fixed at 8, matching the 3-bit select.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  8  req[i]=1 means requester i presents valid data. It must hold req and data stable until ack[i].
- lock  input  8  lock[i]=1 with req[i] asks to keep the grant after this word.
- din  input  512  packed data; din[64*i+63 : 64*i] belongs to requester i.
- ack  output  8  one-hot, 1-cycle pulse in the cycle requester i's word is captured.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  consumer accepts the word when out_valid && out_ready at a clock edge.
- out_data  output  64  registered word.
- out_src  output  3  index of the requester that produced out_data.

Behaviour:
- Reset values: out_valid=0, out_data=0, out_src=0, ack=0, priority pointer ptr=0, lock_active=0, lock_owner=0. reset has priority over all other events; an in-flight word is dropped and no ack fires.
- Capture condition: cap_en = (!out_valid || out_ready) && (|req).
- Arbitration is combinational each cycle:
  - If lock_active and req[lock_owner]=1, winner = lock_owner.
  - Otherwise winner = first i with req[i]=1, searching ptr, ptr+1, ..., ptr+7 mod 8 (wrap-around from 7 to 0).
- sel = winner drives the mux.
- On a cap_en edge:
  - out_data <= mux output, out_src <= winner, out_valid <= 1.
  - ack[winner] = 1, combinational in the capture cycle: ack = cap_en ? onehot(winner) : 0.
  - ptr <= winner+1 mod 8, only when lock_active is not retained.
  - lock_active <= lock[winner]; lock_owner <= winner.
- Not capturing with out_valid && out_ready: out_valid <= 0.
- out_valid && !out_ready: out_data and out_src hold, ack=0, and ptr and lock state hold (stall).
- Latency is 1 cycle from capture to out_valid. Throughput is 1 word per cycle when out_ready is held high.
- Lock release:
  - If the lock owner drops req, the lock is released and normal round-robin resumes from ptr. ptr was not advanced during the lock, so it still points just past the owner's first locked grant.
  - A lock on a word whose lock bit is 0 ends after that word.
- Simultaneous consumer accept and new capture in the same edge: the output is replaced with no bubble.
- No requests and out_valid=0: idle; outputs hold their last data values, out_valid=0.

Decomposition:
- Shared package wb_arb_pkg holds:
  - localparam NREQ=8, SELW=3, WIDTH=64.
  - typedef logic [SELW-1:0] src_t.
  - function rr_pick(req, ptr) returning src_t.
- Sub-module: the existing mux8_1x64, fed din slices on in0..in7 and winner on sel. All other logic, including the pointer, lock and output register, lives in a single always_ff plus a comb block.

Test Plan:
- Reset then idle: assert reset for 2 cycles mid-stream with out_valid=1 -> the next cycle shows out_valid=0, out_data=0, out_src=0, ack=0; then req=0 for 5 cycles -> out_valid stays 0.
- Fairness: req=8'hFF held, out_ready=1, din[i]=64'hA0+i -> out_src sequence 0,1,...,7,0 on consecutive cycles; ack is one-hot matching each source. The bench drops req[i] one cycle after ack[i] and re-raises it.
- Wrap and skip: ptr=6 (after a grant to 5), req=8'b0000_0101 -> grant 0 then 2; out_data=din0 then din2.
- Backpressure: out_ready=0 for 3 cycles with req=8'h03 -> out_data/out_src frozen on the first word, ack=0 during the stall; raise out_ready -> the next word (src 1) appears the following cycle.
- Locked burst: req=8'h09, lock[3]=1 for 3 words, ptr=3 -> src 3,3,3. Then lock[3]=0 on the final word -> src 3, then 0.
- Full throughput with accept plus capture: out_ready=1, req=8'h80 constant with din7 counting 1,2,3 -> out_data 1,2,3 on consecutive cycles with no bubbles.
